// File: rtl/frame_topk_sorter.sv
// rtl/frame_topk_sorter.sv - per-frame top-K sorter, emits the K largest samples in descending order
module frame_topk_sorter #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter int RW         = $clog2(K)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [RW-1:0]         m_rank,
    output logic                  m_last
);

    localparam int CW = $clog2(K + 1);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]            state;
    logic                  run;
    logic [CW-1:0]         cnt;
    logic [RW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] bank [K];

    logic [CW-1:0]         ins_pos;
    logic [CW-1:0]         cnt_next;
    logic [DATA_WIDTH-1:0] bank_ins [K];
    logic                  s_fire;
    logic                  m_fire;
    logic                  drain;

    // run holds s_ready low until the first clock edge after reset release
    assign drain   = (state == DRAIN);
    assign s_ready = run && !drain;
    assign m_valid = drain;
    assign s_fire  = s_valid && s_ready;
    assign m_fire  = m_valid && m_ready;

    assign m_data = drain ? bank[rd_idx] : '0;
    assign m_rank = drain ? rd_idx : '0;
    assign m_last = drain && (CW'(rd_idx) == (cnt - CW'(1)));

    assign cnt_next = (cnt == CW'(K)) ? cnt : (cnt + CW'(1));

    // Insert position: equal values land below existing entries, keeping arrival order among ties
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < K; i++) begin
            if ((CW'(i) < cnt) && (bank[i] >= s_data)) begin
                ins_pos = ins_pos + CW'(1);
            end
        end
    end

    always_comb begin
        bank_ins[0] = (ins_pos == '0) ? s_data : bank[0];
        for (int i = 1; i < K; i++) begin
            if (CW'(i) < ins_pos) begin
                bank_ins[i] = bank[i];
            end else if (CW'(i) == ins_pos) begin
                bank_ins[i] = s_data;
            end else begin
                bank_ins[i] = bank[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ACCUM;
            run    <= 1'b0;
            cnt    <= '0;
            rd_idx <= '0;
            for (int i = 0; i < K; i++) begin
                bank[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            case (state)
                ACCUM: begin
                    if (s_fire) begin
                        for (int i = 0; i < K; i++) begin
                            bank[i] <= bank_ins[i];
                        end
                        cnt <= cnt_next;
                        if (s_last) begin
                            state  <= DRAIN;
                            rd_idx <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (m_fire) begin
                        if (m_last) begin
                            state  <= ACCUM;
                            cnt    <= '0;
                            rd_idx <= '0;
                            for (int i = 0; i < K; i++) begin
                                bank[i] <= '0;
                            end
                        end else begin
                            rd_idx <= rd_idx + RW'(1);
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_topk_sorter.sv
// tb/tb_frame_topk_sorter.sv - directed self-checking bench for frame_topk_sorter
module tb_frame_topk_sorter;

    localparam int DATA_WIDTH = 32;
    localparam int K          = 4;
    localparam int RW         = $clog2(K);

    logic                  clk;
    logic                  resetn;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [RW-1:0]         m_rank;
    logic                  m_last;

    int checks;
    int errors;

    frame_topk_sorter #(.DATA_WIDTH(DATA_WIDTH), .K(K)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_rank  (m_rank),
        .m_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one sample; called #1 after a rising edge, returns #1 after the accepting edge
    task automatic send(input logic [31:0] d, input logic l);
        check("s_ready_before_send", s_ready, 1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
    endtask

    // Check the presented result, then let it be consumed with m_ready high
    task automatic expect_out(input string tag, input logic [31:0] d, input int r, input logic l);
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_data"},  m_data, d);
        check({tag, "_rank"},  m_rank, r);
        check({tag, "_last"},  m_last, l);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_idle_ready"}, s_ready, 1);
        check({tag, "_idle_valid"}, m_valid, 0);
        check({tag, "_idle_data"},  m_data, 0);
        check({tag, "_idle_last"},  m_last, 0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data",  m_data, 0);
        check("rst_m_rank",  m_rank, 0);
        check("rst_m_last",  m_last, 0);
        resetn = 1'b1;
        #2;
        check("rel_s_ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1;
        check("rel_s_ready_after_edge", s_ready, 1);

        // 5,9,1,7,3 -> 9,7,5,3
        send(5, 0); send(9, 0); send(1, 0); send(7, 0);
        check("f1_no_early_valid", m_valid, 0);
        send(3, 1);
        expect_out("f1_r0", 9, 0, 0);
        expect_out("f1_r1", 7, 1, 0);
        expect_out("f1_r2", 5, 2, 0);
        expect_out("f1_r3", 3, 3, 1);
        expect_idle("f1");

        // short frame 8,2
        send(8, 0); send(2, 1);
        expect_out("f2_r0", 8, 0, 0);
        expect_out("f2_r1", 2, 1, 1);
        expect_idle("f2");

        // ties and overflow: 4,4,6,4,4 -> 6,4,4,4
        send(4, 0); send(4, 0); send(6, 0); send(4, 0); send(4, 1);
        expect_out("f3_r0", 6, 0, 0);
        expect_out("f3_r1", 4, 1, 0);
        expect_out("f3_r2", 4, 2, 0);
        expect_out("f3_r3", 4, 3, 1);
        expect_idle("f3");

        // backpressure in DRAIN with s_valid held high
        send(1, 0);
        m_ready = 1'b0;
        send(2, 1);
        s_valid = 1'b1;
        s_data  = 99;
        s_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("f4_stall_valid", m_valid, 1);
            check("f4_stall_data",  m_data, 2);
            check("f4_stall_rank",  m_rank, 0);
            check("f4_stall_ready", s_ready, 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        expect_out("f4_r0", 2, 0, 0);
        expect_out("f4_r1", 1, 1, 1);
        expect_idle("f4");

        // unsigned compare at the extremes
        send(32'hFFFF_FFFF, 0); send(0, 1);
        expect_out("f5_r0", 32'hFFFF_FFFF, 0, 0);
        expect_out("f5_r1", 0, 1, 1);
        expect_idle("f5");

        // reset mid-drain discards the remaining results
        send(10, 0); send(20, 0); send(30, 0); send(40, 1);
        expect_out("f6_r0", 40, 0, 0);
        expect_out("f6_r1", 30, 1, 0);
        resetn = 1'b0;
        #1;
        check("f6_rst_m_valid", m_valid, 0);
        check("f6_rst_m_data",  m_data, 0);
        check("f6_rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        check("f6_rst_hold_ready", s_ready, 0);
        resetn = 1'b1;
        #2;
        check("f6_rel_ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1;
        check("f6_rel_m_valid", m_valid, 0);
        send(3, 1);
        expect_out("f7_r0", 3, 0, 1);
        expect_idle("f7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
